dsp_arith_unit: RTL and testbench
=================================

Name: dsp_arith_unit

Overview:
- Single-cycle, registered DSP-style arithmetic slice for the RV32I core's ALU datapath.
- Provides the following operations on 32-bit operands:
  - 32-bit add
  - reverse subtract (input2 - input1)
  - 16x16 unsigned multiply
  - shift-left-by-multiply
- The ALU instantiates it in place of inferred adders, subtractors and shifters so that these map onto iCE40 MAC16 resources.
- Result is registered: one-cycle latency.

Parameters:
- None. Widths are fixed: 32-bit word, 16-bit multiplier/shift operands, 4-bit shift amount.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands and op are sampled when high.
- op  in  3  operation select (encoding in Behaviour).
- input1  in  32  operand 1.
- input2  in  32  operand 2.
- out  out  32  registered result.
- carry  out  1  registered carry/borrow flag.
- out_valid  out  1  high one cycle after an accepted input.

Behaviour:
- Reset: on a rising clk with reset=1, out=0, carry=0, out_valid=0. Reset wins over a simultaneous in_valid. Reset asserted mid-stream drops the in-flight result.
- Latency: inputs are captured on the rising clk where in_valid=1. The result appears on out/carry with out_valid=1 after that same edge, so it is usable in the next cycle.
- in_valid=0: out_valid=0 on the next edge; out and carry hold their previous values.
- Back-to-back: in_valid high every cycle produces one result per cycle. No stalls, no backpressure.
- op 3'b000 ADD:
  - out = (input1 + input2) mod 2^32.
  - carry = carry out of bit 31.
- op 3'b001 SUB:
  - out = (input2 - input1) mod 2^32. This is the DSP convention: the ALU drives input1=B, input2=A to get A-B.
  - carry = 1 iff input2 < input1 unsigned (borrow).
- op 3'b010 MUL16:
  - out = input1[15:0] * input2[15:0], unsigned, full 32-bit product.
  - carry = 0.
- op 3'b011 SHL16:
  - out = {16'b0, input1[15:0]} << input2[3:0], built as input1[15:0] * (16'b1 << input2[3:0]).
  - input2[31:4] is ignored. carry = 0.
- op 3'b100 / 3'b101: AND / XOR; defined under Optional Feature.
- Any other op, or 100/101 with the feature compiled out: out = 0, carry = 0, out_valid still asserted.
- All arithmetic is unsigned and wraps modulo 2^32. No overflow traps. Operand values 0 and 0xFFFFFFFF are legal.

Optional Feature:
- Macro: DSP_ANDXOR_EN.
- When defined, bitwise ops are computed through the adder via bit interleaving:
  - Spread A[15:0] into even bit positions of a 32-bit word (odd bits 0); do the same for B.
  - Sum them: bit 2i of the sum = A[i]^B[i]; bit 2i+1 = A[i]&B[i].
  - Low and high halves use two independent spread-adds.
  - op 3'b100 AND: out = input1 & input2.
  - op 3'b101 XOR: out = input1 ^ input2.
  - carry = 0 for both.
- When undefined: no spread logic is built, and ops 100/101 return 0 as illegal ops.

Decomposition:
- Package dsp_arith_pkg holds:
  - op encoding localparams: OP_ADD, OP_SUB, OP_MUL16, OP_SHL16, OP_AND, OP_XOR.
  - width constants: WORD_W=32, HALF_W=16, SHAMT_W=4.
- One natural sub-module: dsp_mul16, a combinational 16x16 unsigned multiplier shared by MUL16 and SHL16.
- Bit-spread logic is a function inside the top module.

Test Plan:
- Reset with in_valid=1 for one cycle -> out=0, carry=0, out_valid=0. Release reset, idle -> outputs unchanged.
- ADD 0xFFFFFFFF + 0x00000001 -> out=0x00000000, carry=1. Then ADD 0x12345678 + 0x11111111 -> out=0x23456789, carry=0 on the next cycle (back-to-back).
- SUB input1=5, input2=3 -> out=0xFFFFFFFE, carry=1. SUB input1=3, input2=5 -> out=2, carry=0.
- MUL16 0xFFFF*0xFFFF -> out=0xFFFE0001. SHL16 input1=0x8001, input2=15 -> out=0x40008000. SHL16 input2=0x10 (shamt 0) -> out=input1[15:0].
- With DSP_ANDXOR_EN: AND 0xF0F0A5A5 & 0xFF00FF00 -> out=0xF000A500; XOR same operands -> out=0x0FF05AA5. Without the macro, both ops -> out=0.
- in_valid toggling 1,0,1 -> out_valid 1,0,1 with one-cycle lag; out holds during the gap. Assert reset while a result is pending -> out_valid=0, out=0.

Source files
------------

// File: rtl/dsp_arith_pkg.sv
// Shared constants for the DSP arithmetic slice: operation encodings and
// fixed datapath widths.
package dsp_arith_pkg;

  localparam int WORD_W  = 32;
  localparam int HALF_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL16 = 3'b010;
  localparam logic [2:0] OP_SHL16 = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;

endpackage

// File: rtl/dsp_mul16.sv
// Combinational 16x16 unsigned multiplier with a full 32-bit product.
// The top uses it for both MUL16 and SHL16 so that both land on one MAC.
module dsp_mul16
  import dsp_arith_pkg::*;
(
  input  logic [HALF_W-1:0] i_a,
  input  logic [HALF_W-1:0] i_b,
  output logic [WORD_W-1:0] o_p
);

  // Zero-extend both operands so the product is formed at full width.
  assign o_p = {{(WORD_W-HALF_W){1'b0}}, i_a} * {{(WORD_W-HALF_W){1'b0}}, i_b};

endmodule

// File: rtl/dsp_arith_unit.sv
// Registered DSP arithmetic slice: ADD, reverse SUB, 16x16 MUL, and
// shift-left built as a multiply by a one-hot power of two. One-cycle latency.
// Optional bitwise AND/XOR through spread-add when DSP_ANDXOR_EN is defined;
// without it, ops 100/101 behave as illegal ops (result 0).
module dsp_arith_unit
  import dsp_arith_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] input1,
  input  logic [WORD_W-1:0] input2,
  output logic [WORD_W-1:0] out,
  output logic              carry,
  output logic              out_valid
);

  localparam logic [HALF_W-1:0] ONE_HALF = {{(HALF_W-1){1'b0}}, 1'b1};

  logic [WORD_W:0]   w_sum;
  logic [WORD_W:0]   w_diff;
  logic [HALF_W-1:0] w_mul_b;
  logic [WORD_W-1:0] w_mul_p;
  logic [WORD_W-1:0] w_result;
  logic              w_carry;

  logic [WORD_W-1:0] r_out;
  logic              r_carry;
  logic              r_valid;

  // Carry/borrow fall out of bit 32 of a 33-bit add/subtract.
  assign w_sum  = {1'b0, input1} + {1'b0, input2};
  assign w_diff = {1'b0, input2} - {1'b0, input1};

  // SHL16 multiplies by 2^shamt, so the multiplier's B port is either the
  // low half of input2 or a one-hot word selected by input2[3:0].
  assign w_mul_b = (op == OP_SHL16) ? (ONE_HALF << input2[SHAMT_W-1:0])
                                    : input2[HALF_W-1:0];

  dsp_mul16 u_mul16 (
    .i_a (input1[HALF_W-1:0]),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

`ifdef DSP_ANDXOR_EN
  logic [WORD_W-1:0] w_spread_lo;
  logic [WORD_W-1:0] w_spread_hi;
  logic [WORD_W-1:0] w_and;
  logic [WORD_W-1:0] w_xor;

  // Place each bit of a half-word at an even position; the odd position
  // above it absorbs the pair's carry, so no carry ever crosses pairs.
  function automatic logic [WORD_W-1:0] spread16(input logic [HALF_W-1:0] v);
    logic [WORD_W-1:0] s;
    s = '0;
    for (int i = 0; i < HALF_W; i++) begin
      s[2*i] = v[i];
    end
    return s;
  endfunction

  assign w_spread_lo = spread16(input1[HALF_W-1:0])      + spread16(input2[HALF_W-1:0]);
  assign w_spread_hi = spread16(input1[WORD_W-1:HALF_W]) + spread16(input2[WORD_W-1:HALF_W]);

  // Even sum bits are the XOR of each pair, odd sum bits are the AND.
  genvar gi;
  generate
    for (gi = 0; gi < HALF_W; gi++) begin : g_unspread
      assign w_xor[gi]          = w_spread_lo[2*gi];
      assign w_and[gi]          = w_spread_lo[2*gi+1];
      assign w_xor[gi + HALF_W] = w_spread_hi[2*gi];
      assign w_and[gi + HALF_W] = w_spread_hi[2*gi+1];
    end
  endgenerate
`endif

  // Result/flag select by opcode; unknown ops yield zero.
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (op)
      OP_ADD: begin
        w_result = w_sum[WORD_W-1:0];
        w_carry  = w_sum[WORD_W];
      end
      OP_SUB: begin
        w_result = w_diff[WORD_W-1:0];
        w_carry  = w_diff[WORD_W];
      end
      OP_MUL16: w_result = w_mul_p;
      OP_SHL16: w_result = w_mul_p;
`ifdef DSP_ANDXOR_EN
      OP_AND:   w_result = w_and;
      OP_XOR:   w_result = w_xor;
`endif
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
      end
    endcase
  end

  // Output register: capture on in_valid, hold otherwise; reset clears all.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out   <= w_result;
        r_carry <= w_carry;
      end
    end
  end

  assign out       = r_out;
  assign carry     = r_carry;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_dsp_arith_unit.sv
// Self-checking bench for dsp_arith_unit: table vectors run back-to-back,
// hand-written gap/reset sequences, and random vectors against a model.
// Expected AND/XOR results follow DSP_ANDXOR_EN.
module tb_dsp_arith_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_carry;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        carry;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] out;
  logic        carry;
  logic        out_valid;

  int checks;
  int errors;

  exp_t        sb_q[$];
  logic [31:0] hold_out;
  logic        hold_carry;

  localparam int NVEC = 13;
  vec_t tbl[NVEC];

  dsp_arith_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .input1    (input1),
    .input2    (input2),
    .out       (out),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Independent reference built from plain operators.
  function automatic exp_t model(input logic [2:0] m_op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] t;
    e.out   = '0;
    e.carry = 1'b0;
    case (m_op)
      3'd0: begin
        t       = {1'b0, a} + {1'b0, b};
        e.out   = t[31:0];
        e.carry = t[32];
      end
      3'd1: begin
        e.out   = b - a;
        e.carry = (b < a);
      end
      3'd2: e.out = {16'h0, a[15:0]} * {16'h0, b[15:0]};
      3'd3: e.out = {16'h0, a[15:0]} << b[3:0];
`ifdef DSP_ANDXOR_EN
      3'd4: e.out = a & b;
      3'd5: e.out = a ^ b;
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Drive one accepted transaction and queue its expected result.
  task automatic drive(input logic [2:0] d_op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_out, input logic e_carry);
    exp_t e;
    in_valid = 1'b1;
    op       = d_op;
    input1   = a;
    input2   = b;
    e.out    = e_out;
    e.carry  = e_carry;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b0;
    op       = 3'd0;
    input1   = a;
    input2   = b;
  endtask

  // Advance one clock and compare; a valid output pops the scoreboard,
  // an idle cycle must leave out/carry at their held values.
  task automatic step(input string tag, input logic exp_valid);
    exp_t e;
    @(posedge clk);
    #1;
    chk1({tag, ".valid"}, out_valid, exp_valid);
    if (exp_valid) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s.queue: got empty expected entry", tag);
      end else begin
        e = sb_q.pop_front();
        chk32({tag, ".out"}, out, e.out);
        chk1({tag, ".carry"}, carry, e.carry);
        hold_out   = e.out;
        hold_carry = e.carry;
      end
    end else begin
      chk32({tag, ".hold_out"}, out, hold_out);
      chk1({tag, ".hold_carry"}, carry, hold_carry);
    end
    $display("step %s: valid=%b out=%h carry=%b", tag, out_valid, out, carry);
  endtask

  task automatic reset_cycle(input string tag, input logic with_valid);
    reset    = 1'b1;
    in_valid = with_valid;
    op       = 3'd0;
    input1   = 32'h1234_0001;
    input2   = 32'h0000_0002;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk32({tag, ".out"}, out, 32'h0);
    chk1({tag, ".carry"}, carry, 1'b0);
    chk1({tag, ".valid"}, out_valid, 1'b0);
    $display("reset %s: valid=%b out=%h carry=%b", tag, out_valid, out, carry);
    hold_out   = 32'h0;
    hold_carry = 1'b0;
    reset      = 1'b0;
  endtask

  logic [31:0] and_exp;
  logic [31:0] xor_exp;

  initial begin
    checks     = 0;
    errors     = 0;
    hold_out   = '0;
    hold_carry = 1'b0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    op         = 3'd0;
    input1     = '0;
    input2     = '0;

`ifdef DSP_ANDXOR_EN
    and_exp = 32'hF000_A500;
    xor_exp = 32'h0FF0_5AA5;
`else
    and_exp = 32'h0;
    xor_exp = 32'h0;
`endif

    tbl[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[1]  = '{3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    tbl[2]  = '{3'b001, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFE, 1'b1};
    tbl[3]  = '{3'b001, 32'h0000_0003, 32'h0000_0005, 32'h0000_0002, 1'b0};
    tbl[4]  = '{3'b010, 32'hABCD_FFFF, 32'h1234_FFFF, 32'hFFFE_0001, 1'b0};
    tbl[5]  = '{3'b011, 32'h0000_8001, 32'h0000_000F, 32'h4000_8000, 1'b0};
    tbl[6]  = '{3'b011, 32'h5555_1234, 32'h0000_0010, 32'h0000_1234, 1'b0};
    tbl[7]  = '{3'b100, 32'hF0F0_A5A5, 32'hFF00_FF00, and_exp,       1'b0};
    tbl[8]  = '{3'b101, 32'hF0F0_A5A5, 32'hFF00_FF00, xor_exp,       1'b0};
    tbl[9]  = '{3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[10] = '{3'b111, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[11] = '{3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[12] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};

    // Reset wins over a simultaneous in_valid.
    reset_cycle("reset_init", 1'b1);
    idle(32'hDEAD_BEEF, 32'h1);
    step("idle0", 1'b0);
    step("idle1", 1'b0);

    // Table vectors, back-to-back with in_valid high every cycle.
    drive(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].exp_out, tbl[0].exp_carry);
    for (int i = 1; i < NVEC; i++) begin
      step($sformatf("vec%0d", i - 1), 1'b1);
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_out, tbl[i].exp_carry);
    end
    step($sformatf("vec%0d", NVEC - 1), 1'b1);

    // in_valid 1,0,1: out_valid follows one cycle later, out holds in the gap.
    drive(3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0);
    step("gap_a", 1'b1);
    idle(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("gap_idle", 1'b0);
    drive(3'b001, 32'h0000_0010, 32'h0000_0004, 32'hFFFF_FFF4, 1'b1);
    step("gap_b", 1'b1);

    // Reset arriving on the same edge as an accepted input drops it.
    drive(3'b010, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 1'b0);
    reset_cycle("reset_inflight", 1'b1);
    idle(32'h0, 32'h0);
    step("post_reset", 1'b0);

    // Reset after a result is presented clears it.
    drive(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    step("pre_reset", 1'b1);
    reset_cycle("reset_after", 1'b0);

    // Random vectors over every opcode, checked against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      exp_t        e;
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      if (i % 8 == 0) r_a = 32'hFFFF_FFFF;
      e = model(r_op, r_a, r_b);
      drive(r_op, r_a, r_b, e.out, e.carry);
      step($sformatf("rnd%0d_op%0d", i, r_op), 1'b1);
    end
    idle(32'h0, 32'h0);
    step("final_idle", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
